// File: rtl/mac_row_feeder_if.sv
// Handshake bundle between the row feeder, its upstream job source and the PE row X-axis.
// slave: the feeder's view. master: the view of whatever drives jobs and models the row.
interface mac_row_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  reuse_weights;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  a_valid;
  logic                  a_ready;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_last;
  logic                  valid_out_x;
  logic                  ready_in_x;
  logic                  weight_shift_out;
  logic [DATA_WIDTH-1:0] x_out;
  logic                  east_shift_ack;
  logic                  weight_latch_en;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, reuse_weights, w_valid, w_data, a_valid, a_data, a_last,
           ready_in_x, east_shift_ack,
    output w_ready, a_ready, valid_out_x, weight_shift_out, x_out,
           weight_latch_en, busy, done
  );

  modport master (
    output start, reuse_weights, w_valid, w_data, a_valid, a_data, a_last,
           ready_in_x, east_shift_ack,
    input  w_ready, a_ready, valid_out_x, weight_shift_out, x_out,
           weight_latch_en, busy, done
  );
endinterface

// File: rtl/mac_row_feeder.sv
// West-edge transmitter for one row of mac_pe cells. Per job it shifts COLS weight tokens
// into the row, waits for all of them to leave the east edge, pulses weight_latch_en, then
// streams activations until a_last.
//
// state  | meaning
// IDLE   | no job; waiting for start
// LOAD   | accepting weight words, sending them as shift tokens
// DRAIN  | all weights sent; waiting for COLS east-edge acks
// LATCH  | one-cycle weight_latch_en pulse
// STREAM | accepting activations until a_last
module mac_row_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 4
) (
  input logic             clk,
  input logic             rst_n,
  mac_row_feeder_if.slave bus
);

  localparam int CW = $clog2(COLS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, LATCH, STREAM} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         w_cnt, ack_cnt;
  logic                  valid_q, shift_q, done_q, latch_en;
  logic [DATA_WIDTH-1:0] x_q;
  logic                  slot_free, w_fire, a_fire, ack_hit, acks_complete;

  assign slot_free   = !valid_q || bus.ready_in_x;
  assign bus.w_ready = (state == LOAD) && slot_free && (w_cnt < CW'(COLS));
  assign bus.a_ready = (state == STREAM) && slot_free;
  assign w_fire      = bus.w_valid && bus.w_ready;
  assign a_fire      = bus.a_valid && bus.a_ready;

  // Acks only count while weights are in flight; later ones belong to no load and are dropped.
  assign ack_hit = bus.east_shift_ack && ((state == LOAD) || (state == DRAIN))
                   && (ack_cnt < CW'(COLS));

  // Include the ack arriving this cycle so the latch follows the last ack by exactly one cycle.
  assign acks_complete = (ack_cnt == CW'(COLS)) || (ack_hit && (ack_cnt == CW'(COLS - 1)));

  assign bus.valid_out_x      = valid_q;
  assign bus.weight_shift_out = shift_q;
  assign bus.x_out            = x_q;
  assign bus.done             = done_q;
  assign bus.weight_latch_en  = latch_en;
  assign bus.busy             = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the latch strobe.
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_nxt = bus.reuse_weights ? STREAM : LOAD;
      LOAD:    if (w_fire && (w_cnt == CW'(COLS - 1))) state_nxt = DRAIN;
      DRAIN:   if (acks_complete) state_nxt = LATCH;
      LATCH: begin
        latch_en  = 1'b1;
        state_nxt = STREAM;
      end
      STREAM:  if (a_fire && bus.a_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weight and ack counters, cleared when a loading job starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt   <= '0;
      ack_cnt <= '0;
    end else if ((state == IDLE) && bus.start && !bus.reuse_weights) begin
      w_cnt   <= '0;
      ack_cnt <= '0;
    end else begin
      if (w_fire)  w_cnt   <= w_cnt + 1'b1;
      if (ack_hit) ack_cnt <= ack_cnt + 1'b1;
    end
  end

  // Single-entry X-axis output stage; a token holds until PE0 takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      shift_q <= 1'b0;
      x_q     <= '0;
    end else if (w_fire) begin
      valid_q <= 1'b1;
      shift_q <= 1'b1;
      x_q     <= bus.w_data;
    end else if (a_fire) begin
      valid_q <= 1'b1;
      shift_q <= 1'b0;
      x_q     <= bus.a_data;
    end else if (bus.ready_in_x) begin
      valid_q <= 1'b0;
    end
  end

  // Done pulses the cycle after the final activation enters the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= a_fire && bus.a_last;
  end

endmodule

// File: tb/tb_mac_row_feeder.sv
// Self-checking bench for mac_row_feeder: a cycle-accurate job model built from handshake
// rules and event timing, plus literal expectations on token order and pulse timing.
module tb_mac_row_feeder;
  localparam int DW   = 8;
  localparam int COLS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_row_feeder_if #(.DATA_WIDTH(DW)) bus ();

  mac_row_feeder #(.DATA_WIDTH(DW), .COLS(COLS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Row model: every shift token taken by PE0 exits the east edge two cycles later.
  logic tok_seen = 1'b0, ack_d1 = 1'b0, ack_d2 = 1'b0, stray_ack = 1'b0;
  assign bus.east_shift_ack = ack_d2 | stray_ack;

  always @(negedge clk)
    tok_seen = rst_n && bus.valid_out_x && bus.ready_in_x && bus.weight_shift_out;

  always @(posedge clk) begin
    #1;
    ack_d2 = ack_d1;
    ack_d1 = tok_seen;
  end

  // Observation logs used by the literal checks.
  logic [8:0] seen[$];
  int ack_q[$];
  int latch_cnt = 0, latch_seen_cyc = -1, done_cnt = 0, done_seen_cyc = -1;

  // Job model state.
  bit m_busy, m_wph, m_ackph, m_str, m_valid, m_shift, was_busy;
  logic [7:0] m_x;
  int m_wcnt, m_acks, m_lastw_cyc, m_ack_cyc, m_latch_cyc, m_done_cyc;
  bit exp_slot, exp_wr, exp_ar, m_wfire, m_afire;

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", bus.valid_out_x, 0);
      chk("rst_shift", bus.weight_shift_out, 0);
      chk("rst_x", bus.x_out, 0);
      chk("rst_latch", bus.weight_latch_en, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_w_ready", bus.w_ready, 0);
      chk("rst_a_ready", bus.a_ready, 0);
      chk("rst_busy", bus.busy, 0);
      m_busy = 0; m_wph = 0; m_ackph = 0; m_str = 0; m_valid = 0; m_shift = 0; m_x = '0;
      m_wcnt = 0; m_acks = 0; m_lastw_cyc = -10; m_ack_cyc = -10;
      m_latch_cyc = -10; m_done_cyc = -10;
    end else begin
      exp_slot = !m_valid || bus.ready_in_x;
      exp_wr   = m_wph && exp_slot;
      exp_ar   = m_str && exp_slot;
      chk("w_ready", bus.w_ready, exp_wr);
      chk("a_ready", bus.a_ready, exp_ar);
      chk("valid_out_x", bus.valid_out_x, m_valid);
      chk("weight_shift_out", bus.weight_shift_out, m_shift);
      chk("x_out", bus.x_out, m_x);
      chk("weight_latch_en", bus.weight_latch_en, cyc == m_latch_cyc);
      chk("done", bus.done, cyc == m_done_cyc);
      chk("busy", bus.busy, m_busy);

      if (bus.valid_out_x && bus.ready_in_x) seen.push_back({bus.weight_shift_out, bus.x_out});
      if (bus.east_shift_ack) ack_q.push_back(cyc);
      if (bus.weight_latch_en) begin latch_cnt++; latch_seen_cyc = cyc; end
      if (bus.done) begin done_cnt++; done_seen_cyc = cyc; end

      was_busy = m_busy;
      m_wfire  = exp_wr && bus.w_valid;
      m_afire  = exp_ar && bus.a_valid;
      if (m_wfire) begin
        m_valid = 1; m_shift = 1; m_x = bus.w_data;
      end else if (m_afire) begin
        m_valid = 1; m_shift = 0; m_x = bus.a_data;
      end else if (bus.ready_in_x) begin
        m_valid = 0;
      end
      if (m_ackph && bus.east_shift_ack && m_acks < COLS) begin
        m_acks++;
        if (m_acks == COLS) m_ack_cyc = cyc;
      end
      if (m_wfire) begin
        m_wcnt++;
        if (m_wcnt == COLS) begin m_wph = 0; m_lastw_cyc = cyc; end
      end
      // Latch needs at least one drain cycle after the last weight and one cycle after the last ack.
      if (m_ackph && m_acks == COLS && m_wcnt == COLS && m_latch_cyc < 0)
        m_latch_cyc = (m_ack_cyc + 1 > m_lastw_cyc + 2) ? m_ack_cyc + 1 : m_lastw_cyc + 2;
      if (cyc == m_latch_cyc) begin m_ackph = 0; m_str = 1; end
      if (m_afire && bus.a_last) begin m_str = 0; m_busy = 0; m_done_cyc = cyc + 1; end
      if (!was_busy && bus.start) begin
        m_busy = 1;
        if (bus.reuse_weights) m_str = 1;
        else begin
          m_wph = 1; m_ackph = 1; m_wcnt = 0; m_acks = 0; m_latch_cyc = -10;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit reuse);
    bus.start = 1; bus.reuse_weights = reuse;
    step();
    bus.start = 0; bus.reuse_weights = 0;
  endtask

  task automatic send_w(input logic [7:0] d);
    bit fired = 0;
    bus.w_valid = 1; bus.w_data = d;
    for (int i = 0; i < 60 && !fired; i++) begin
      @(negedge clk);
      fired = bus.w_ready;
      step();
    end
    bus.w_valid = 0;
    chk("w_accepted", fired, 1);
  endtask

  int last_fire_cyc = -1;

  task automatic send_a(input logic [7:0] d, input bit last);
    bit fired = 0;
    bus.a_valid = 1; bus.a_data = d; bus.a_last = last;
    for (int i = 0; i < 60 && !fired; i++) begin
      @(negedge clk);
      fired = bus.a_ready;
      if (fired) last_fire_cyc = cyc;
      step();
    end
    bus.a_valid = 0; bus.a_last = 0;
    chk("a_accepted", fired, 1);
  endtask

  task automatic wait_done();
    bit got = (done_cnt > 0);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = bus.done;
    end
    step();
    chk("done_seen", got, 1);
  endtask

  task automatic clear_logs();
    seen.delete(); ack_q.delete();
    latch_cnt = 0; latch_seen_cyc = -1; done_cnt = 0; done_seen_cyc = -1;
  endtask

  task automatic chk_seen(input string name, input logic [8:0] exp[], input int n);
    chk({name, "_count"}, seen.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_tok%0d", name, i), (i < seen.size()) ? seen[i] : 9'h1ff, exp[i]);
  endtask

  logic [8:0] exp_t23[] = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h005, 9'h0FD, 9'h07F, 9'h080};
  logic [8:0] exp_t4[]  = '{9'h00A, 9'h014, 9'h01E, 9'h028};
  logic [8:0] exp_t5[]  = '{9'h005, 9'h0FD, 9'h07F, 9'h080};
  logic [8:0] exp_t6[]  = '{9'h011, 9'h022};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // T1: random inputs under reset
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'($urandom); bus.reuse_weights = 1'($urandom);
      bus.w_valid = 1'($urandom); bus.w_data = 8'($urandom);
      bus.a_valid = 1'($urandom); bus.a_data = 8'($urandom); bus.a_last = 1'($urandom);
      bus.ready_in_x = 1'($urandom);
      step();
    end
    bus.start = 0; bus.reuse_weights = 0; bus.w_valid = 0; bus.w_data = 0;
    bus.a_valid = 0; bus.a_data = 0; bus.a_last = 0; bus.ready_in_x = 1;
    step();
    rst_n = 1;
    clear_logs();
    repeat (3) step();
    chk("t1_busy_idle", bus.busy, 0);
    chk("t1_no_tokens", seen.size(), 0);

    // T2 + T3: load 1..4 then stream 5,-3,127,-128
    clear_logs();
    do_start(0);
    send_w(8'd1); send_w(8'd2); send_w(8'd3); send_w(8'd4);
    send_a(8'd5, 0); send_a(8'hFD, 0); send_a(8'h7F, 0); send_a(8'h80, 1);
    wait_done();
    chk_seen("t23", exp_t23, 8);
    chk("t2_ack_count", ack_q.size(), COLS);
    chk("t2_latch_count", latch_cnt, 1);
    chk("t2_latch_after_ack", latch_seen_cyc, (ack_q.size() >= COLS) ? ack_q[COLS-1] + 1 : -1);
    chk("t3_done_count", done_cnt, 1);
    chk("t3_done_latency", done_seen_cyc, last_fire_cyc + 1);
    chk("t3_busy_fell", bus.busy, 0);

    // T4: backpressure mid-stream on a reuse job
    clear_logs();
    do_start(1);
    fork
      begin
        send_a(8'd10, 0); send_a(8'd20, 0); send_a(8'd30, 0); send_a(8'd40, 1);
      end
      begin
        repeat (2) step();
        bus.ready_in_x = 0;
        repeat (3) step();
        bus.ready_in_x = 1;
      end
    join
    wait_done();
    chk_seen("t4", exp_t4, 4);
    chk("t4_latch_count", latch_cnt, 0);

    // T5: reuse weights, same activations as T3
    clear_logs();
    do_start(1);
    send_a(8'd5, 0); send_a(8'hFD, 0); send_a(8'h7F, 0); send_a(8'h80, 1);
    wait_done();
    chk_seen("t5", exp_t5, 4);
    chk("t5_latch_count", latch_cnt, 0);
    chk("t5_done_latency", done_seen_cyc, last_fire_cyc + 1);

    // T6: stray ack and start while busy, then async reset mid-LOAD
    clear_logs();
    do_start(1);
    send_a(8'h11, 0);
    stray_ack = 1; bus.start = 1;
    step();
    stray_ack = 0; bus.start = 0;
    send_a(8'h22, 1);
    wait_done();
    repeat (3) step();
    chk_seen("t6", exp_t6, 2);
    chk("t6_latch_count", latch_cnt, 0);
    chk("t6_busy_after", bus.busy, 0);

    clear_logs();
    do_start(0);
    send_w(8'h55); send_w(8'h66);
    #3 rst_n = 0;
    #1;
    chk("t6_async_busy", bus.busy, 0);
    chk("t6_async_valid", bus.valid_out_x, 0);
    chk("t6_async_x", bus.x_out, 0);
    chk("t6_async_w_ready", bus.w_ready, 0);
    repeat (2) step();
    rst_n = 1;
    clear_logs();
    repeat (4) step();
    chk("t6_post_busy", bus.busy, 0);
    chk("t6_post_tokens", seen.size(), 0);
    chk("t6_post_latch", latch_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
